// File: rtl/store_queue.sv
// rtl/store_queue.sv - in-order store queue with occupancy status, flush and youngest-match store forwarding
module store_queue #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int AF_THRESH  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [DATA_WIDTH/8-1:0] in_strb,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_addr,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [DATA_WIDTH/8-1:0] out_strb,
  input  logic                    flush,
  output logic [4:0]              count,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_full,
  input  logic [ADDR_WIDTH-1:0]   lk_addr,
  output logic                    lk_hit,
  output logic [DATA_WIDTH-1:0]   lk_data,
  output logic [DATA_WIDTH/8-1:0] lk_strb
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);

  // Entry payload is never reset: every reader is gated by valid_q or empty.
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [SW-1:0]         strb_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic [4:0] count_q;
  logic       push;
  logic       pop;
  logic [4:0] scan;

  function automatic logic [3:0] next_ptr(input logic [3:0] p);
    return (p == LAST_IDX) ? 4'd0 : p + 4'd1;
  endfunction

  assign count       = count_q;
  assign empty       = (count_q == 5'd0);
  assign full        = (count_q == 5'(DEPTH));
  assign almost_full = (count_q >= 5'(AF_THRESH));

  // Flush masks both handshakes so that nothing completes in a flush cycle.
  assign in_ready  = ~full & ~flush;
  assign out_valid = ~empty & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_addr = empty ? '0 : addr_q[rd_ptr[IW-1:0]];
  assign out_data = empty ? '0 : data_q[rd_ptr[IW-1:0]];
  assign out_strb = empty ? '0 : strb_q[rd_ptr[IW-1:0]];

  // Pointer, valid-bit and occupancy state; flush returns everything to the reset picture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      count_q <= 5'd0;
      valid_q <= '0;
    end else if (flush) begin
      wr_ptr  <= 4'd0;
      rd_ptr  <= 4'd0;
      count_q <= 5'd0;
      valid_q <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr[IW-1:0]] <= 1'b1;
        wr_ptr                  <= next_ptr(wr_ptr);
      end
      if (pop) begin
        valid_q[rd_ptr[IW-1:0]] <= 1'b0;
        rd_ptr                  <= next_ptr(rd_ptr);
      end
      if (push && !pop) begin
        count_q <= count_q + 5'd1;
      end else if (pop && !push) begin
        count_q <= count_q - 5'd1;
      end
    end
  end

  // Entry payload capture on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr[IW-1:0]] <= in_addr;
      data_q[wr_ptr[IW-1:0]] <= in_data;
      strb_q[wr_ptr[IW-1:0]] <= in_strb;
    end
  end

  // Lookup walks slots oldest-to-youngest starting at wr_ptr, so the last match is the youngest.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_strb = '0;
    scan    = 5'd0;
    for (int k = 0; k < DEPTH; k++) begin
      scan = {1'b0, wr_ptr} + 5'(k);
      if (scan >= 5'(DEPTH)) begin
        scan = scan - 5'(DEPTH);
      end
      if (valid_q[scan[IW-1:0]] && (addr_q[scan[IW-1:0]] == lk_addr)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[scan[IW-1:0]];
        lk_strb = strb_q[scan[IW-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_store_queue.sv
// tb/tb_store_queue.sv - scoreboard bench for store_queue at DEPTH=8 and DEPTH=5
module tb_store_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic        a_empty, a_full, a_af, a_lk_hit;
  logic [31:0] a_in_addr, a_in_data, a_out_addr, a_out_data, a_lk_addr, a_lk_data;
  logic [3:0]  a_in_strb, a_out_strb, a_lk_strb;
  logic [4:0]  a_count;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic        b_empty, b_full, b_af, b_lk_hit;
  logic [31:0] b_in_addr, b_in_data, b_out_addr, b_out_data, b_lk_addr, b_lk_data;
  logic [3:0]  b_in_strb, b_out_strb, b_lk_strb;
  logic [4:0]  b_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_a [$];
  logic [63:0] exp_b [$];

  store_queue #(.DEPTH(8), .DATA_WIDTH(32), .ADDR_WIDTH(32), .AF_THRESH(6)) u_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_addr(a_in_addr), .in_data(a_in_data), .in_strb(a_in_strb),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_addr(a_out_addr), .out_data(a_out_data), .out_strb(a_out_strb),
    .flush(a_flush), .count(a_count), .empty(a_empty), .full(a_full), .almost_full(a_af),
    .lk_addr(a_lk_addr), .lk_hit(a_lk_hit), .lk_data(a_lk_data), .lk_strb(a_lk_strb)
  );

  store_queue #(.DEPTH(5), .DATA_WIDTH(32), .ADDR_WIDTH(32), .AF_THRESH(4)) u_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_addr(b_in_addr), .in_data(b_in_data), .in_strb(b_in_strb),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_addr(b_out_addr), .out_data(b_out_data), .out_strb(b_out_strb),
    .flush(b_flush), .count(b_count), .empty(b_empty), .full(b_full), .almost_full(b_af),
    .lk_addr(b_lk_addr), .lk_hit(b_lk_hit), .lk_data(b_lk_data), .lk_strb(b_lk_strb)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus on instance a (sel=0) or b (sel=1); handshakes are scored at the negedge.
  task automatic cycle(input bit sel, input bit iv, input logic [31:0] ad, input logic [31:0] da,
                       input bit ordy);
    logic [63:0] e;
    if (!sel) begin
      a_in_valid = iv; a_in_addr = ad; a_in_data = da; a_out_ready = ordy;
    end else begin
      b_in_valid = iv; b_in_addr = ad; b_in_data = da; b_out_ready = ordy;
    end
    @(negedge clk);
    if (!sel) begin
      if (a_out_valid && a_out_ready) begin
        if (exp_a.size() == 0) check("a_pop_unexpected", 1, 0);
        else begin
          e = exp_a.pop_front();
          check("a_pop_addr", a_out_addr, e[63:32]);
          check("a_pop_data", a_out_data, e[31:0]);
          check("a_pop_strb", a_out_strb, 4'hF);
        end
      end
      if (a_in_valid && a_in_ready) exp_a.push_back({ad, da});
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (exp_b.size() == 0) check("b_pop_unexpected", 1, 0);
        else begin
          e = exp_b.pop_front();
          check("b_pop_addr", b_out_addr, e[63:32]);
          check("b_pop_data", b_out_data, e[31:0]);
        end
      end
      if (b_in_valid && b_in_ready) exp_b.push_back({ad, da});
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_in_valid = 0; a_in_addr = 0; a_in_data = 0; a_in_strb = 4'hF; a_out_ready = 0; a_flush = 0; a_lk_addr = 0;
    b_in_valid = 0; b_in_addr = 0; b_in_data = 0; b_in_strb = 4'hF; b_out_ready = 0; b_flush = 0; b_lk_addr = 0;
    #12;
    check("rst_count", a_count, 5'd0);
    check("rst_empty", a_empty, 1'b1);
    check("rst_full", a_full, 1'b0);
    check("rst_af", a_af, 1'b0);
    check("rst_in_ready", a_in_ready, 1'b1);
    check("rst_out_valid", a_out_valid, 1'b0);
    check("rst_out_data", a_out_data, 32'd0);
    check("rst_lk_hit", a_lk_hit, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Fill to full, then a refused ninth push.
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 32'h100 + 32'(4 * k), 32'hA0 + 32'(k), 0);
      check("fill_count", a_count, 5'(k + 1));
      check("fill_af", a_af, (k + 1) >= 6);
    end
    check("fill_full", a_full, 1'b1);
    check("fill_in_ready", a_in_ready, 1'b0);
    cycle(0, 1, 32'h1FC, 32'hEE, 0);
    check("refuse_count", a_count, 5'd8);

    // First pop from full frees space on the following cycle.
    cycle(0, 0, 0, 0, 1);
    check("space_in_ready", a_in_ready, 1'b1);
    check("space_count", a_count, 5'd7);
    for (int k = 0; k < 9; k++) cycle(0, 0, 0, 0, 1);
    check("drain_count", a_count, 5'd0);
    check("drain_empty", a_empty, 1'b1);
    check("drain_out_data", a_out_data, 32'd0);
    check("drain_sb_empty", exp_a.size(), 0);

    // Steady push+pop at count 3 across two pointer wraps.
    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h300 + 32'(4 * k), 32'hB0 + 32'(k), 0);
    for (int k = 0; k < 20; k++) begin
      cycle(0, 1, 32'h380 + 32'(4 * k), 32'hC0 + 32'(k), 1);
      check("pp_count", a_count, 5'd3);
    end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 1);
    check("pp_empty", a_empty, 1'b1);

    // Forwarding; these three entries straddle the slot-7 to slot-0 wrap.
    a_lk_addr = 32'h200;
    cycle(0, 1, 32'h200, 32'h11, 0);
    check("fwd_first", a_lk_data, 32'h11);
    a_in_valid = 1; a_in_addr = 32'h200; a_in_data = 32'h22;
    @(negedge clk);
    check("fwd_inflight_hidden", a_lk_data, 32'h11);
    if (a_in_ready) exp_a.push_back({32'h200, 32'h22});
    @(posedge clk); #1;
    a_in_valid = 0;
    cycle(0, 1, 32'h204, 32'h33, 0);
    a_lk_addr = 32'h200; #1;
    check("fwd_hit", a_lk_hit, 1'b1);
    check("fwd_youngest", a_lk_data, 32'h22);
    check("fwd_strb", a_lk_strb, 4'hF);
    a_lk_addr = 32'h204; #1;
    check("fwd_other", a_lk_data, 32'h33);
    a_lk_addr = 32'h208; #1;
    check("fwd_miss_hit", a_lk_hit, 1'b0);
    check("fwd_miss_data", a_lk_data, 32'd0);
    a_lk_addr = 32'h200;
    cycle(0, 0, 0, 0, 1);
    check("fwd_after_pop1", a_lk_data, 32'h22);
    cycle(0, 0, 0, 0, 1);
    check("fwd_after_pop2", a_lk_hit, 1'b0);
    cycle(0, 0, 0, 0, 1);

    // Flush with concurrent push and pop requests.
    for (int k = 0; k < 4; k++) cycle(0, 1, 32'h600 + 32'(4 * k), 32'hD0 + 32'(k), 0);
    check("pre_flush_count", a_count, 5'd4);
    a_in_valid = 1; a_out_ready = 1; a_flush = 1; a_in_addr = 32'h6F0; a_in_data = 32'hDD;
    @(negedge clk);
    check("flush_in_ready", a_in_ready, 1'b0);
    check("flush_out_valid", a_out_valid, 1'b0);
    @(posedge clk); #1;
    a_in_valid = 0; a_out_ready = 0; a_flush = 0;
    exp_a.delete();
    check("flush_count", a_count, 5'd0);
    check("flush_empty", a_empty, 1'b1);
    cycle(0, 1, 32'h400, 32'h55, 0);
    check("post_flush_wr_ptr", u_a.wr_ptr, 4'd1);
    check("post_flush_rd_ptr", u_a.rd_ptr, 4'd0);
    check("post_flush_out", a_out_data, 32'h55);
    cycle(0, 0, 0, 0, 1);

    // Asynchronous reset between edges during a burst.
    for (int k = 0; k < 3; k++) cycle(0, 1, 32'h500 + 32'(4 * k), 32'hE0 + 32'(k), 0);
    a_lk_addr = 32'h500;
    a_in_valid = 1; a_in_addr = 32'h50C; a_in_data = 32'hE3;
    #2 reset = 1'b1;
    #1;
    check("arst_count", a_count, 5'd0);
    check("arst_empty", a_empty, 1'b1);
    check("arst_out_valid", a_out_valid, 1'b0);
    check("arst_out_data", a_out_data, 32'd0);
    check("arst_lk_hit", a_lk_hit, 1'b0);
    a_in_valid = 0;
    exp_a.delete();
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("arst_release_count", a_count, 5'd0);

    // DEPTH=5: non-power-of-two wrap and full/almost_full.
    for (int k = 0; k < 3; k++) cycle(1, 1, 32'h700 + 32'(4 * k), 32'hF0 + 32'(k), 0);
    for (int k = 0; k < 20; k++) begin
      cycle(1, 1, 32'h780 + 32'(4 * k), 32'h70 + 32'(k), 1);
      check("b_pp_count", b_count, 5'd3);
    end
    check("b_af3", b_af, 1'b0);
    for (int k = 0; k < 2; k++) cycle(1, 1, 32'h7F0 + 32'(4 * k), 32'h90 + 32'(k), 0);
    check("b_full", b_full, 1'b1);
    check("b_af", b_af, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1, 0, 0, 0, 1);
    check("b_empty", b_empty, 1'b1);
    check("b_sb_empty", exp_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_queue.md
# store_queue

Parametrised in-order store queue for the CPU's data-side write path. It sits between the memory stage, which pushes retiring stores, and the data-cache/AXI write interface, which drains them. It extends a plain circular FIFO with several additions:
- arbitrary depth and width,
- valid/ready handshakes on both sides,
- occupancy count and almost-full flag,
- synchronous flush,
- an associative lookup port that forwards the youngest matching store's data to loads.

## Interface
Parameters:
- DEPTH, 8, number of entries; any integer 2..16 (not restricted to powers of two)
- DATA_WIDTH, 32, store data width; multiple of 8
- ADDR_WIDTH, 32, store address width; all bits compared on lookup
- AF_THRESH, 6, almost_full asserts when count >= AF_THRESH; range 1..DEPTH

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  producer offers a store
- in_ready  out  1  queue accepts; = ~full & ~flush
- in_addr  in  ADDR_WIDTH  store address
- in_data  in  DATA_WIDTH  store data
- in_strb  in  DATA_WIDTH/8  byte enables
- out_valid  out  1  head entry available; = ~empty & ~flush
- out_ready  in  1  consumer takes head
- out_addr / out_data / out_strb  out  as above  head entry fields; all zero when empty
- flush  in  1  discard all entries
- count  out  5  number of valid entries, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AF_THRESH
- lk_addr  in  ADDR_WIDTH  load address to search
- lk_hit  out  1  some valid entry has addr == lk_addr
- lk_data / lk_strb  out  DATA_WIDTH, DATA_WIDTH/8  fields of the youngest matching entry; zero when lk_hit = 0

## Operation
- Storage: DEPTH entries of {addr, data, strb}, plus a per-entry valid bit.
- Pointers: wr_ptr and rd_ptr are 4-bit and wrap from DEPTH-1 to 0.
- Push: fires when in_valid & in_ready. The entry at wr_ptr is written, its valid bit is set, and wr_ptr advances.
- Pop: fires when out_valid & out_ready. The valid bit at rd_ptr is cleared and rd_ptr advances.
- Push and pop in the same cycle are both performed; count is unchanged.
- in_ready does not depend on out_ready. A full queue refuses a push even when a pop occurs in the same cycle.
- count update: +1 on push only, -1 on pop only, unchanged when both or neither fire.
- Flush: wins over push and pop. Next state is all valid bits clear, wr_ptr = rd_ptr = 0, count = 0.
  - Because in_ready and out_valid are forced low during flush, no handshake completes in a flush cycle.
- Lookup: purely combinational over the committed (registered) entries.
  - A match requires valid & (addr == lk_addr).
  - Youngest = the match closest behind wr_ptr in wrap order.
  - A store being pushed in the same cycle is not visible. An entry being popped in the same cycle is still visible.
- Registers are not cleared by pop or flush. Outputs are masked with valid bits instead.

## Timing
- Reset state (asynchronous, immediate):
  - count = 0, empty = 1, full = 0, almost_full = 0
  - in_ready = 1, out_valid = 0
  - out_addr / out_data / out_strb = 0
  - lk_hit = 0, lk_data = 0, lk_strb = 0
- Reset asserted mid-operation drops all entries. No handshake completes in the cycle reset is released.
- Push-to-out latency: 1 cycle. A store pushed at edge N appears at out_* and in lookup results after edge N; there is no same-cycle bypass.
- Pop-to-space latency: 1 cycle. in_ready rises in the cycle after a pop from full.
- All status outputs (count, empty, full, almost_full) are registered-state derived and change only at clock edges.
- Wrap-around: pointers at DEPTH-1 go to 0. The order of out_* and the youngest-match selection stay correct across the wrap.
- Full: in_valid held high is ignored and no entry is overwritten.
- Empty: out_ready held high has no effect; count never underflows.

## Test plan
- Reset then idle: after reset pulse with DEPTH=8 → count=0, empty=1, in_ready=1, out_valid=0, out_data=0, lk_hit=0.
- Fill and drain: push 8 stores, addr 0x100+4k and data 0xA0+k, out_ready=0 → full=1, in_ready=0, almost_full from count=6. A 9th push is refused. Draining with out_ready=1 yields data 0xA0..0xA7 in order.
- Simultaneous push/pop at count=3 for 20 cycles → count stays 3, pointers wrap twice, FIFO order preserved. Repeat with DEPTH=5 to check non-power-of-two wrap.
- Forwarding: push addr 0x200 with data 0x11 then 0x22, and 0x204 with data 0x33, each strb 0xF. lk_addr=0x200 → lk_hit=1, lk_data=0x22. After both 0x200 entries pop → lk_hit=0. lk_addr=0x208 → lk_hit=0, lk_data=0.
- Flush with concurrent push and pop requests at count=4 → in_ready=0 and out_valid=0 that cycle. Next cycle count=0, empty=1, and a fresh push lands at entry 0.
- Asynchronous reset asserted mid-burst between clock edges → outputs go to reset values immediately, without waiting for a clock edge.
